// File: rtl/tx_comma_serializer_pkg.sv
// ----------------------------------------------------------------------------
// serdes_tx_pkg
// Shared definitions for the transmit comma serializer slice:
//   SYMBOL_W    - width of one line symbol (fixed at 10)
//   K28_5_RDN   - K28.5 comma, running disparity negative (10'h0FA)
//   K28_5_RDP   - K28.5 comma, running disparity positive (10'h305)
//   LAST_BIT    - bit index of the final bit of a symbol
//   tx_state_e  - serializer FSM encoding (IDLE / COMMA / DATA)
// ----------------------------------------------------------------------------
package serdes_tx_pkg;

   localparam int SYMBOL_W = 10;

   localparam logic [SYMBOL_W-1:0] K28_5_RDN = 10'h0FA;
   localparam logic [SYMBOL_W-1:0] K28_5_RDP = 10'h305;

   localparam logic [3:0] LAST_BIT = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COMMA = 2'b01,
      ST_DATA  = 2'b10
   } tx_state_e;

endpackage

// File: rtl/tx_comma_serializer_if.sv
// ----------------------------------------------------------------------------
// tx_comma_serializer_if
// Symbol handshake between the upstream 8b/10b encoder and the serializer.
//   tx_data  - 10-bit encoded symbol offered by upstream
//   tx_valid - tx_data holds a symbol
//   tx_ready - serializer is loading its symbol slot this cycle
//
// Handshake: a symbol transfers in exactly the cycle where tx_ready and
// tx_valid are both high. tx_ready is a one-cycle pulse raised once per
// symbol slot (the last bit of the previous symbol); it does not wait for
// tx_valid. If tx_valid is low in that cycle the slot is filled with a comma
// and the upstream symbol (if any arrives later) waits for the next slot.
// tx_data/tx_valid are ignored whenever tx_ready is low.
//   master - upstream encoder side
//   slave  - serializer side
// ----------------------------------------------------------------------------
interface tx_comma_serializer_if;
   import serdes_tx_pkg::*;

   logic [SYMBOL_W-1:0] tx_data;
   logic                tx_valid;
   logic                tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/tx_comma_serializer_piso.sv
// ----------------------------------------------------------------------------
// tx_piso_10b
// Parallel-in / serial-out symbol register. Shifts right so the symbol leaves
// LSB-first; zeros are shifted in from the top.
//   clk, rst - clock and synchronous active-high reset
//   clear    - force the register to zero (highest priority after rst)
//   load     - load din
//   shift    - shift right by one
//   din      - parallel symbol
//   sout     - current line bit (register bit 0)
// ----------------------------------------------------------------------------
module tx_piso_10b
   import serdes_tx_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                load,
   input  logic                shift,
   input  logic [SYMBOL_W-1:0] din,
   output logic                sout
);

   logic [SYMBOL_W-1:0] shift_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         shift_reg <= '0;
      end else if (load) begin
         shift_reg <= din;
      end else if (shift) begin
         shift_reg <= {1'b0, shift_reg[SYMBOL_W-1:1]};
      end
   end

   assign sout = shift_reg[0];

endmodule

// File: rtl/tx_comma_serializer.sv
// ----------------------------------------------------------------------------
// tx_comma_serializer
// Transmit framer for the 10-bit PHY lane. When enabled it sends a burst of
// K28.5 alignment commas (alternating RD-/RD+), then serializes upstream
// symbols LSB-first, one bit per clk. Empty data slots are filled with
// commas that continue the RD-/RD+ alternation.
//
// Ports:
//   clk          - bit-rate clock
//   rst          - synchronous active-high reset
//   tx_en        - link enable (level); sampled in IDLE and at symbol ends
//   comma_number - alignment comma count, captured on leaving IDLE (0 -> 1)
//   up           - symbol handshake (slave side, see tx_comma_serializer_if)
//   serial_out   - line bit
//   symbol_pulse - high during bit 9 of every transmitted symbol
//   state_o      - FSM state: 00 IDLE, 01 COMMA, 10 DATA
//   underrun_cnt - (only with TX_UNDERRUN_CNT_EN) saturating count of data
//                  slots filled with a comma because tx_valid was low
//
// Build option: define TX_UNDERRUN_CNT_EN to add underrun_cnt.
// ----------------------------------------------------------------------------
module tx_comma_serializer
   import serdes_tx_pkg::*;
#(
   parameter logic [SYMBOL_W-1:0] COMMA_P = K28_5_RDN,
   parameter logic [SYMBOL_W-1:0] COMMA_N = K28_5_RDP
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tx_en,
   input  logic [2:0]                 comma_number,
   tx_comma_serializer_if.slave       up,
   output logic                       serial_out,
   output logic                       symbol_pulse,
   output logic [1:0]                 state_o
`ifdef TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]                underrun_cnt
`endif
);

   tx_state_e           state;
   logic [3:0]          bit_cnt;
   logic [2:0]          comma_cnt;   // alignment commas completed so far
   logic [2:0]          n_lat;       // captured alignment comma target
   logic                disp_n;      // next alternating comma is COMMA_N

   logic                slot_end;
   logic                commas_done;
   logic                ready_c;
   logic                load_comma;
   logic                piso_clear;
   logic                piso_load;
   logic                piso_shift;
   logic [SYMBOL_W-1:0] piso_din;

   // Slot decisions are taken in the last bit of a symbol so the next symbol
   // is in the shift register in time for its bit 0. tx_ready has to be
   // combinational on tx_en because upstream samples it in the same cycle it
   // presents tx_valid.
   always_comb begin
      slot_end    = (state != ST_IDLE) && (bit_cnt == LAST_BIT);
      commas_done = (({1'b0, comma_cnt} + 4'd1) >= {1'b0, n_lat});
      ready_c     = slot_end && tx_en && ((state == ST_DATA) || commas_done);
      load_comma  = slot_end && tx_en &&
                    (((state == ST_COMMA) && !commas_done) ||
                     (ready_c && !up.tx_valid));

      piso_clear  = 1'b0;
      piso_load   = 1'b0;
      piso_shift  = (state != ST_IDLE);
      piso_din    = disp_n ? COMMA_N : COMMA_P;

      if (state == ST_IDLE) begin
         if (tx_en) begin
            piso_load = 1'b1;
            piso_din  = COMMA_P;
         end else begin
            piso_clear = 1'b1;
         end
      end else if (slot_end) begin
         if (!tx_en) begin
            // Symbol finished with the link disabled: line drops to 0.
            piso_clear = 1'b1;
         end else if (load_comma) begin
            piso_load = 1'b1;
         end else if (ready_c) begin
            piso_load = 1'b1;
            piso_din  = up.tx_data;
         end
      end
   end

   tx_piso_10b u_piso (
      .clk   (clk),
      .rst   (rst),
      .clear (piso_clear),
      .load  (piso_load),
      .shift (piso_shift),
      .din   (piso_din),
      .sout  (serial_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         comma_cnt <= '0;
         n_lat     <= '0;
         disp_n    <= 1'b0;
      end else begin
         // Only alternating commas flip the disparity toggle; data does not.
         if (load_comma) begin
            disp_n <= ~disp_n;
         end

         case (state)
            ST_IDLE: begin
               if (tx_en) begin
                  state     <= ST_COMMA;
                  bit_cnt   <= '0;
                  comma_cnt <= '0;
                  n_lat     <= (comma_number == 3'd0) ? 3'd1 : comma_number;
                  // COMMA_P is being loaded now, so the next one is COMMA_N.
                  disp_n    <= 1'b1;
               end
            end

            ST_COMMA, ST_DATA: begin
               bit_cnt <= slot_end ? 4'd0 : (bit_cnt + 4'd1);
               if (slot_end) begin
                  if (!tx_en) begin
                     state <= ST_IDLE;
                  end else if (state == ST_COMMA) begin
                     comma_cnt <= comma_cnt + 3'd1;
                     if (commas_done) begin
                        state <= ST_DATA;
                     end
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef TX_UNDERRUN_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_cnt <= '0;
      end else if (ready_c && !up.tx_valid && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

   assign up.tx_ready   = ready_c;
   assign symbol_pulse  = slot_end;
   assign state_o       = state;

endmodule
